// File: rtl/meduram_pkg.sv
// meduram_pkg: shared LVT entry type and helper functions for the N-write/M-read RAM
package meduram_pkg;

    localparam int MAX_WRAGENT = 8;
    localparam int LVT_ENTRY_W = $clog2(MAX_WRAGENT);

    typedef logic [LVT_ENTRY_W-1:0] lvt_entry_t;

    function automatic int sel_width(int n);
        return n <= 1 ? 1 : $clog2(n);
    endfunction

    function automatic logic [31:0] sat_inc(logic [31:0] v, int w);
        logic [31:0] top;
        top = {32{1'b1}} >> (32 - w);
        return v == top ? v : v + 32'd1;
    endfunction

    function automatic logic in_range(logic [31:0] a, int depth);
        return a < 32'(depth);
    endfunction

endpackage

// File: rtl/meduram_lvt.sv
// meduram_lvt: live value table with lowest-index write priority, collision detect and bypass match
module meduram_lvt import meduram_pkg::*; #(
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 2**ADDR_WIDTH,
    parameter int NB_WR        = 2,
    parameter int NB_RD        = 2,
    parameter int SELECT_WIDTH = sel_width(NB_WR),
    parameter int CNT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NB_WR-1:0]            wren_i,
    input  logic [NB_WR*ADDR_WIDTH-1:0] wraddr_i,
    input  logic [NB_RD*ADDR_WIDTH-1:0] rdaddr_i,
    output lvt_entry_t [NB_RD-1:0]      rd_sel_o,
    output logic [NB_RD-1:0]            byp_hit_o,
    output lvt_entry_t [NB_RD-1:0]      byp_sel_o,
    output logic                        wrcollision_o,
    output logic [CNT_WIDTH-1:0]        collision_cnt_o
);

    logic [SELECT_WIDTH-1:0] lvt_q [RAM_DEPTH];
    logic [ADDR_WIDTH-1:0]   wa [NB_WR];
    logic [ADDR_WIDTH-1:0]   ra [NB_RD];
    logic [NB_WR-1:0]        wr_ok;
    logic                    coll_d, coll_q;
    logic [CNT_WIDTH-1:0]    cnt_q;

    for (genvar g = 0; g < NB_WR; g++) begin : g_wr
        assign wa[g]    = wraddr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_ok[g] = wren_i[g] && in_range(32'(wa[g]), RAM_DEPTH);
    end

    for (genvar h = 0; h < NB_RD; h++) begin : g_rd
        assign ra[h]       = rdaddr_i[h*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_sel_o[h] = in_range(32'(ra[h]), RAM_DEPTH) ? lvt_entry_t'(lvt_q[ra[h]]) : '0;
    end

    // Any pair of in-range writers landing on the same address is a collision
    always_comb begin
        coll_d = 1'b0;
        for (int i = 0; i < NB_WR; i++)
            for (int k = i + 1; k < NB_WR; k++)
                if (wr_ok[i] && wr_ok[k] && wa[i] == wa[k]) coll_d = 1'b1;
    end

    // Per read port, find the lowest-index writer hitting the read address this cycle
    always_comb begin
        byp_hit_o = '0;
        byp_sel_o = '0;
        for (int j = 0; j < NB_RD; j++)
            for (int i = NB_WR - 1; i >= 0; i--)
                if (wr_ok[i] && wa[i] == ra[j]) begin
                    byp_hit_o[j] = 1'b1;
                    byp_sel_o[j] = lvt_entry_t'(i);
                end
    end

    // Highest index is scheduled first so the lowest-index writer's update lands last and wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < RAM_DEPTH; a++) lvt_q[a] <= '0;
        end else begin
            for (int i = NB_WR - 1; i >= 0; i--)
                if (wr_ok[i]) lvt_q[wa[i]] <= SELECT_WIDTH'(i);
        end
    end

    // Collision pulse and saturating collision counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            coll_q <= coll_d;
            cnt_q  <= coll_d ? CNT_WIDTH'(sat_inc(32'(cnt_q), CNT_WIDTH)) : cnt_q;
        end
    end

    assign wrcollision_o   = coll_q;
    assign collision_cnt_o = cnt_q;

endmodule

// File: rtl/meduram_nwmr.sv
// meduram_nwmr: N-write / M-read RAM from one bank per writer steered by a live value table
module meduram_nwmr import meduram_pkg::*; #(
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH   = 32,
    parameter int NB_WRAGENT   = 2,
    parameter int NB_RDAGENT   = 2,
    parameter int SELECT_WIDTH = sel_width(NB_WRAGENT),
    parameter int BYPASS       = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
    input  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
    input  logic [NB_RDAGENT-1:0]            rden,
    input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
    output logic [NB_RDAGENT*DATA_WIDTH-1:0] rddata,
    output logic [NB_RDAGENT-1:0]            rdvalid,
    output logic                             wrcollision,
    output logic [CNT_WIDTH-1:0]             collision_cnt
);

    logic [NB_RDAGENT-1:0][DATA_WIDTH-1:0] bank_rd [NB_WRAGENT];
    logic [NB_RDAGENT-1:0][DATA_WIDTH-1:0] rddata_d, rddata_q;
    logic [NB_RDAGENT-1:0]                 rdvalid_q;
    lvt_entry_t [NB_RDAGENT-1:0]           rd_sel, byp_sel;
    logic [NB_RDAGENT-1:0]                 byp_hit;

    meduram_lvt #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .RAM_DEPTH   (RAM_DEPTH),
        .NB_WR       (NB_WRAGENT),
        .NB_RD       (NB_RDAGENT),
        .SELECT_WIDTH(SELECT_WIDTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_lvt (
        .clk            (aclk),
        .rst_n          (aresetn),
        .wren_i         (wren),
        .wraddr_i       (wraddr),
        .rdaddr_i       (rdaddr),
        .rd_sel_o       (rd_sel),
        .byp_hit_o      (byp_hit),
        .byp_sel_o      (byp_sel),
        .wrcollision_o  (wrcollision),
        .collision_cnt_o(collision_cnt)
    );

    for (genvar g = 0; g < NB_WRAGENT; g++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
        logic [ADDR_WIDTH-1:0] wa;
        assign wa = wraddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        // Bank write port; every enabled writer stores its data, even when it loses the LVT
        always_ff @(posedge aclk) begin
            if (wren[g] && in_range(32'(wa), RAM_DEPTH)) mem[wa] <= wrdata[g*DATA_WIDTH +: DATA_WIDTH];
        end
        for (genvar h = 0; h < NB_RDAGENT; h++) begin : g_port
            logic [ADDR_WIDTH-1:0] ra;
            assign ra            = rdaddr[h*ADDR_WIDTH +: ADDR_WIDTH];
            assign bank_rd[g][h] = in_range(32'(ra), RAM_DEPTH) ? mem[ra] : '0;
        end
    end

    // Steer each read port to the bank named by the LVT, or to the winning writer when forwarding
    always_comb begin
        for (int j = 0; j < NB_RDAGENT; j++)
            rddata_d[j] = (BYPASS != 0 && byp_hit[j]) ? wrdata[byp_sel[j]*DATA_WIDTH +: DATA_WIDTH]
                                                      : bank_rd[rd_sel[j]][j];
    end

    // Registered read outputs; data holds on idle ports
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rddata_q  <= '0;
            rdvalid_q <= '0;
        end else begin
            rdvalid_q <= rden;
            for (int j = 0; j < NB_RDAGENT; j++)
                if (rden[j]) rddata_q[j] <= rddata_d[j];
        end
    end

    assign rddata  = rddata_q;
    assign rdvalid = rdvalid_q;

endmodule
